// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, field widths, mux-select
// encodings and the registered control bundle type.
package decode_stage_pkg;

    localparam int unsigned W_REG   = 5;
    localparam int unsigned W_IMM   = 16;
    localparam int unsigned W_JADDR = 26;
    localparam int unsigned W_OP    = 6;

    localparam logic [W_OP-1:0] OP_RTYPE = 6'd0;
    localparam logic [W_OP-1:0] OP_J     = 6'd2;
    localparam logic [W_OP-1:0] OP_JAL   = 6'd3;
    localparam logic [W_OP-1:0] OP_BEQ   = 6'd4;
    localparam logic [W_OP-1:0] OP_BNE   = 6'd5;
    localparam logic [W_OP-1:0] OP_ADDI  = 6'd8;
    localparam logic [W_OP-1:0] OP_ADDIU = 6'd9;
    localparam logic [W_OP-1:0] OP_SLTI  = 6'd10;
    localparam logic [W_OP-1:0] OP_SLTIU = 6'd11;
    localparam logic [W_OP-1:0] OP_ANDI  = 6'd12;
    localparam logic [W_OP-1:0] OP_ORI   = 6'd13;
    localparam logic [W_OP-1:0] OP_XORI  = 6'd14;
    localparam logic [W_OP-1:0] OP_LUI   = 6'd15;
    localparam logic [W_OP-1:0] OP_LW    = 6'd35;
    localparam logic [W_OP-1:0] OP_SW    = 6'd43;

    localparam logic [W_OP-1:0] F_SLL     = 6'd0;
    localparam logic [W_OP-1:0] F_SRL     = 6'd2;
    localparam logic [W_OP-1:0] F_SRA     = 6'd3;
    localparam logic [W_OP-1:0] F_JR      = 6'd8;
    localparam logic [W_OP-1:0] F_SYSCALL = 6'd12;
    localparam logic [W_OP-1:0] F_ADD     = 6'd32;
    localparam logic [W_OP-1:0] F_ADDU    = 6'd33;
    localparam logic [W_OP-1:0] F_SUB     = 6'd34;
    localparam logic [W_OP-1:0] F_AND     = 6'd36;
    localparam logic [W_OP-1:0] F_OR      = 6'd37;
    localparam logic [W_OP-1:0] F_XOR     = 6'd38;
    localparam logic [W_OP-1:0] F_SLT     = 6'd42;
    localparam logic [W_OP-1:0] F_SLTU    = 6'd43;
    // Not a MIPS funct; the ALU uses it to place imm in the upper half.
    localparam logic [W_OP-1:0] F_LUI     = 6'd63;

    localparam logic [W_REG-1:0] REG_V0 = 5'd2;
    localparam logic [W_REG-1:0] REG_A0 = 5'd4;

    localparam logic IMM_SIGN_EXT = 1'b1;
    localparam logic IMM_ZERO_EXT = 1'b0;

    typedef enum logic [1:0] {
        PC_SRC_NEXT = 2'd0, PC_SRC_JUMP = 2'd1, PC_SRC_BRCH = 2'd2, PC_SRC_REG = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        REG_SRC_ALU = 2'd0, REG_SRC_MEM = 2'd1, REG_SRC_PC8 = 2'd2
    } reg_src_e;

    typedef enum logic [1:0] {
        MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2
    } mem_cmd_e;

    typedef enum logic [1:0] {
        ALU_SRC_REG = 2'd0, ALU_SRC_IMM = 2'd1, ALU_SRC_SHA = 2'd2
    } alu_src_e;

    typedef struct packed {
        logic [W_REG-1:0]   wa;
        logic [W_REG-1:0]   ra1;
        logic [W_REG-1:0]   ra2;
        logic               reg_wen;
        logic               imm_ext;
        logic [W_IMM-1:0]   imm;
        logic [W_JADDR-1:0] addr;
        logic [W_OP-1:0]    alu_op;
        pc_src_e            pc_src;
        mem_cmd_e           mem_cmd;
        alu_src_e           alu_src;
        reg_src_e           reg_src;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        wa: '0, ra1: '0, ra2: '0, reg_wen: 1'b0, imm_ext: 1'b0, imm: '0, addr: '0,
        alu_op: '0, pc_src: PC_SRC_NEXT, mem_cmd: MEM_NOP, alu_src: ALU_SRC_REG,
        reg_src: REG_SRC_ALU
    };

endpackage

// File: rtl/decode_stage_comb.sv
// Pure combinational MIPS instruction -> control bundle mapping, plus flags
// telling the interlock which source registers are genuinely read.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int unsigned RA_REG = 31
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        is_syscall
);

    logic [W_OP-1:0]  op;
    logic [W_OP-1:0]  funct;
    logic [W_REG-1:0] rs, rt, rd;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign funct = inst[5:0];

    always_comb begin
        ctrl       = CTRL_RESET;
        ctrl.ra1   = rs;
        ctrl.ra2   = rt;
        ctrl.imm   = inst[15:0];
        ctrl.addr  = inst[25:0];
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        is_syscall = 1'b0;

        unique case (op)
            OP_RTYPE: begin
                ctrl.wa      = rd;
                ctrl.alu_op  = funct;
                ctrl.reg_wen = 1'b1;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                case (funct)
                    F_SLL, F_SRL, F_SRA: begin
                        ctrl.alu_src = ALU_SRC_SHA;
                        uses_rs      = 1'b0;
                    end
                    F_JR: begin
                        ctrl.pc_src  = PC_SRC_REG;
                        ctrl.reg_wen = 1'b0;
                        uses_rt      = 1'b0;
                    end
                    F_SYSCALL: begin
                        ctrl.ra1     = REG_V0;
                        ctrl.ra2     = REG_A0;
                        ctrl.reg_wen = 1'b0;
                        is_syscall   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.wa      = rt;
                ctrl.reg_wen = 1'b1;
                ctrl.alu_src = ALU_SRC_IMM;
                uses_rs      = 1'b1;
                ctrl.imm_ext = IMM_SIGN_EXT;
                case (op)
                    OP_ADDI:  ctrl.alu_op = F_ADD;
                    OP_ADDIU: ctrl.alu_op = F_ADDU;
                    OP_SLTI:  ctrl.alu_op = F_SLT;
                    OP_SLTIU: ctrl.alu_op = F_SLTU;
                    OP_ANDI: begin ctrl.alu_op = F_AND; ctrl.imm_ext = IMM_ZERO_EXT; end
                    OP_ORI:  begin ctrl.alu_op = F_OR;  ctrl.imm_ext = IMM_ZERO_EXT; end
                    OP_XORI: begin ctrl.alu_op = F_XOR; ctrl.imm_ext = IMM_ZERO_EXT; end
                    default: begin
                        ctrl.alu_op = F_LUI;
                        ctrl.ra1    = '0;
                        uses_rs     = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.wa      = rt;
                ctrl.reg_wen = 1'b1;
                ctrl.imm_ext = IMM_SIGN_EXT;
                ctrl.alu_op  = F_ADD;
                ctrl.alu_src = ALU_SRC_IMM;
                ctrl.reg_src = REG_SRC_MEM;
                ctrl.mem_cmd = MEM_READ;
                uses_rs      = 1'b1;
            end
            OP_SW: begin
                ctrl.imm_ext = IMM_SIGN_EXT;
                ctrl.alu_op  = F_ADD;
                ctrl.alu_src = ALU_SRC_IMM;
                ctrl.mem_cmd = MEM_WRITE;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.imm_ext = IMM_SIGN_EXT;
                ctrl.alu_op  = F_SUB;
                ctrl.pc_src  = PC_SRC_BRCH;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
            end
            OP_J: ctrl.pc_src = PC_SRC_JUMP;
            OP_JAL: begin
                ctrl.wa      = W_REG'(RA_REG);
                ctrl.reg_wen = 1'b1;
                ctrl.reg_src = REG_SRC_PC8;
                ctrl.pc_src  = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: registered control bundle behind valid/ready, with a
// per-register scoreboard interlocking RAW/WAW hazards until writeback.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned W_CPU             = 32,
    parameter int unsigned N_REGS            = 32,
    parameter int unsigned RA_REG            = 31,
    parameter bit          SERIALISE_SYSCALL = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [W_CPU-1:0]          in_inst,
    input  logic [W_CPU-1:0]          in_pc,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W_CPU-1:0]          out_pc,
    output logic [$clog2(N_REGS)-1:0] out_wa,
    output logic [$clog2(N_REGS)-1:0] out_ra1,
    output logic [$clog2(N_REGS)-1:0] out_ra2,
    output logic                      out_reg_wen,
    output logic                      out_imm_ext,
    output logic [W_IMM-1:0]          out_imm,
    output logic [W_JADDR-1:0]        out_addr,
    output logic [W_OP-1:0]           out_alu_op,
    output logic [1:0]                out_pc_src,
    output logic [1:0]                out_mem_cmd,
    output logic [1:0]                out_alu_src,
    output logic [1:0]                out_reg_src,
    input  logic                      wb_valid,
    input  logic [$clog2(N_REGS)-1:0] wb_addr,
    input  logic                      flush,
    output logic                      busy
);

    ctrl_t              dec;
    logic               uses_rs, uses_rt, is_syscall;
    ctrl_t              ctrl_q, ctrl_d;
    logic [W_CPU-1:0]   pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [N_REGS-1:0]  sb_q, sb_d, sb_clr, sb_eff;
    logic               hazard, ready_int, accept;

    decode_comb #(.RA_REG(RA_REG)) u_decode_comb (
        .inst       (in_inst[31:0]),
        .ctrl       (dec),
        .uses_rs    (uses_rs),
        .uses_rt    (uses_rt),
        .is_syscall (is_syscall)
    );

    // The interlock sees this cycle's writeback already retired, so a waiting
    // consumer issues in the same cycle its producer writes back.
    always_comb begin
        sb_clr = '0;
        if (wb_valid) sb_clr[wb_addr] = 1'b1;
        sb_eff    = sb_q & ~sb_clr;
        sb_eff[0] = 1'b0;
        busy      = |sb_q;
        hazard    = (uses_rs && sb_eff[dec.ra1]) || (uses_rt && sb_eff[dec.ra2]) ||
                    (dec.reg_wen && sb_eff[dec.wa]) ||
                    (SERIALISE_SYSCALL && is_syscall && busy);
        ready_int = (!valid_q || out_ready) && !hazard && !flush;
        accept    = in_valid && ready_int;
        in_ready  = ready_int && rst_n;
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        sb_d    = sb_q & ~sb_clr;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            pc_d    = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // Set after clear so an issue wins over a same-register writeback.
        if (accept && dec.reg_wen && dec.wa != '0) sb_d[dec.wa] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RESET;
            pc_q    <= '0;
            sb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            sb_q    <= sb_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_wa      = ctrl_q.wa;
    assign out_ra1     = ctrl_q.ra1;
    assign out_ra2     = ctrl_q.ra2;
    assign out_reg_wen = ctrl_q.reg_wen;
    assign out_imm_ext = ctrl_q.imm_ext;
    assign out_imm     = ctrl_q.imm;
    assign out_addr    = ctrl_q.addr;
    assign out_alu_op  = ctrl_q.alu_op;
    assign out_pc_src  = ctrl_q.pc_src;
    assign out_mem_cmd = ctrl_q.mem_cmd;
    assign out_alu_src = ctrl_q.alu_src;
    assign out_reg_src = ctrl_q.reg_src;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: handshake, decode fields,
// scoreboard interlock, flush and asynchronous reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_wa, out_ra1, out_ra2;
    logic        out_reg_wen, out_imm_ext;
    logic [15:0] out_imm;
    logic [25:0] out_addr;
    logic [5:0]  out_alu_op;
    logic [1:0]  out_pc_src, out_mem_cmd, out_alu_src, out_reg_src;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        busy;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    localparam logic [31:0] I_ADDI_T0   = 32'h2008_0005; // addi $t0,$0,5
    localparam logic [31:0] I_ORI_T1    = 32'h3409_0003; // ori  $t1,$0,3
    localparam logic [31:0] I_ADD_T2    = 32'h0109_5020; // add  $t2,$t0,$t1
    localparam logic [31:0] I_LW_T3     = 32'h8C0B_0004; // lw   $t3,4($0)
    localparam logic [31:0] I_ADDI_T5   = 32'h210D_0001; // addi $t5,$t0,1
    localparam logic [31:0] I_JAL       = 32'h0C00_0100; // jal  0x100
    localparam logic [31:0] I_ADDI_V0   = 32'h2002_0001; // addi $v0,$0,1
    localparam logic [31:0] I_SYSCALL   = 32'h0000_000C;
    localparam logic [31:0] I_UNKNOWN   = 32'hFC00_0000;
    localparam logic [31:0] I_LUI_T4    = 32'h3C0C_1234; // lui  $t4,0x1234

    always #5 clk = ~clk;

    decode_stage #(
        .W_CPU(32), .N_REGS(32), .RA_REG(31), .SERIALISE_SYSCALL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_wa(out_wa), .out_ra1(out_ra1), .out_ra2(out_ra2),
        .out_reg_wen(out_reg_wen), .out_imm_ext(out_imm_ext), .out_imm(out_imm),
        .out_addr(out_addr), .out_alu_op(out_alu_op), .out_pc_src(out_pc_src),
        .out_mem_cmd(out_mem_cmd), .out_alu_src(out_alu_src), .out_reg_src(out_reg_src),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc_src", 32'(out_pc_src), 32'd0);
        chk("rst_mem_cmd", 32'(out_mem_cmd), 32'd0);
        #10 rst_n = 1'b1;

        // back-to-back independent ops
        in_valid = 1'b1; in_inst = I_ADDI_T0; in_pc = 32'h100;
        #1 chk("b2b_ready0", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_valid0", 32'(out_valid), 32'd1);
        chk("b2b_wa0", 32'(out_wa), 32'd8);
        chk("b2b_immext0", 32'(out_imm_ext), 32'd1);
        chk("b2b_imm0", 32'(out_imm), 32'd5);
        chk("b2b_pc0", out_pc, 32'h100);
        chk("b2b_alu0", 32'(out_alu_op), 32'd32);
        in_inst = I_ORI_T1; in_pc = 32'h104;
        #1 chk("b2b_ready1", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_valid1", 32'(out_valid), 32'd1);
        chk("b2b_wa1", 32'(out_wa), 32'd9);
        chk("b2b_immext1", 32'(out_imm_ext), 32'd0);
        chk("b2b_alu1", 32'(out_alu_op), 32'd37);
        chk("b2b_alusrc1", 32'(out_alu_src), 32'd1);

        // RAW stall on $t0/$t1, released by writeback bypass
        in_inst = I_ADD_T2; in_pc = 32'h108;
        #1 chk("raw_stall0", 32'(in_ready), 32'd0);
        tick();
        chk("raw_drain", 32'(out_valid), 32'd0);
        wb_valid = 1'b1; wb_addr = 5'd9;
        #1 chk("raw_stall1", 32'(in_ready), 32'd0);
        tick();
        wb_addr = 5'd8;
        #1 chk("raw_bypass", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("raw_valid", 32'(out_valid), 32'd1);
        chk("raw_wa", 32'(out_wa), 32'd10);
        chk("raw_ra1", 32'(out_ra1), 32'd8);
        chk("raw_ra2", 32'(out_ra2), 32'd9);
        chk("raw_pc", out_pc, 32'h108);

        // backpressure with LW held
        in_inst = I_LW_T3; in_pc = 32'h10C;
        tick();
        out_ready = 1'b0; in_inst = I_ORI_T1; in_pc = 32'h110;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_mem", 32'(out_mem_cmd), 32'd1);
            chk("bp_regsrc", 32'(out_reg_src), 32'd1);
            chk("bp_wa", 32'(out_wa), 32'd11);
            chk("bp_pc", out_pc, 32'h10C);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // same-cycle set and clear on $t0: set wins
        in_valid = 1'b1; in_inst = I_ADDI_T0; in_pc = 32'h200;
        wb_valid = 1'b1; wb_addr = 5'd8;
        tick();
        wb_valid = 1'b0;
        chk("sc_busy", 32'(busy), 32'd1);
        in_inst = I_ADDI_T5;
        #1 chk("sc_t0_pending", 32'(in_ready), 32'd0);
        in_valid = 1'b0; wb_valid = 1'b1;
        wb_addr = 5'd8;  tick();
        wb_addr = 5'd10; tick();
        wb_addr = 5'd11; tick();
        wb_valid = 1'b0;
        chk("sc_empty", 32'(busy), 32'd0);

        // JAL then SYSCALL serialisation
        in_valid = 1'b1; in_inst = I_JAL; in_pc = 32'h300;
        tick();
        chk("jal_wa", 32'(out_wa), 32'd31);
        chk("jal_regsrc", 32'(out_reg_src), 32'd2);
        chk("jal_pcsrc", 32'(out_pc_src), 32'd1);
        chk("jal_wen", 32'(out_reg_wen), 32'd1);
        chk("jal_addr", 32'(out_addr), 32'h100);
        in_inst = I_ADDI_V0;
        tick();
        in_inst = I_SYSCALL; in_pc = 32'h308;
        #1 chk("sys_stall0", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b1; wb_addr = 5'd2;
        #1 chk("sys_stall1", 32'(in_ready), 32'd0);
        tick();
        wb_addr = 5'd31;
        #1 chk("sys_stall2", 32'(in_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1 chk("sys_go", 32'(in_ready), 32'd1);
        tick();
        chk("sys_valid", 32'(out_valid), 32'd1);
        chk("sys_ra1", 32'(out_ra1), 32'd2);
        chk("sys_ra2", 32'(out_ra2), 32'd4);
        chk("sys_wen", 32'(out_reg_wen), 32'd0);

        // flush keeps the scoreboard
        in_inst = I_ADDI_T0; in_pc = 32'h400;
        tick();
        chk("fl_pre", 32'(out_valid), 32'd1);
        in_inst = I_ORI_T1; flush = 1'b1;
        #1 chk("fl_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);

        // unknown opcode passes as NOP; LUI
        in_inst = I_UNKNOWN; in_pc = 32'h500;
        tick();
        chk("unk_valid", 32'(out_valid), 32'd1);
        chk("unk_wen", 32'(out_reg_wen), 32'd0);
        chk("unk_mem", 32'(out_mem_cmd), 32'd0);
        chk("unk_pcsrc", 32'(out_pc_src), 32'd0);
        in_inst = I_LUI_T4;
        tick();
        chk("lui_alu", 32'(out_alu_op), 32'd63);
        chk("lui_ra1", 32'(out_ra1), 32'd0);
        chk("lui_wa", 32'(out_wa), 32'd12);

        // asynchronous reset mid-stall
        in_inst = I_ADD_T2;
        #1 chk("rs_stall", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd0);
        chk("rs_wa", 32'(out_wa), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined successor to the single-cycle MIPS decoder.
- Sits between the fetch stage and the execute stage.
- Decodes one instruction per cycle into a registered control bundle, behind valid/ready handshakes on both sides.
- Keeps a per-register scoreboard of in-flight writes and interlocks on RAW/WAW hazards until writeback clears them.
- Adds JAL, JR and LUI support, plus SYSCALL serialisation.

Parameters:
- W_CPU, 32, instruction and data width.
- N_REGS, 32, architectural register count; register address width is log2(N_REGS).
- RA_REG, 31, register written by JAL.
- SERIALISE_SYSCALL, 1, when set, SYSCALL waits for an empty scoreboard.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_inst  in  W_CPU  instruction word.
- in_pc  in  W_CPU  PC of the instruction.
- in_ready  out  1  decode accepts this cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  W_CPU  registered PC.
- out_wa, out_ra1, out_ra2  out  log2(N_REGS) each  register addresses.
- out_reg_wen  out  1  register write enable.
- out_imm_ext  out  1  1 = sign extend, 0 = zero extend.
- out_imm  out  16  immediate field.
- out_addr  out  26  jump address field.
- out_alu_op  out  6  ALU function code.
- out_pc_src, out_mem_cmd, out_alu_src, out_reg_src  out  shared widths  mux selects.
- wb_valid  in  1  a writeback completed.
- wb_addr  in  log2(N_REGS)  register written.
- flush  in  1  squash the decode output (branch redirect).
- busy  out  1  scoreboard non-empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, scoreboard = all zero.
  - All out_* fields = 0, with out_pc_src = PC_SRC_NEXT and out_mem_cmd = MEM_NOP.
  - in_ready = 0 while reset is asserted.
- Latency: one cycle. An instruction accepted on edge N appears with out_valid = 1 after edge N.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - While out_valid && !out_ready, all out_* fields hold stable.
- Decode table:
  - R-type: wa = rd, alu_op = funct. SLL/SRL/SRA use ALU_SRC_SHA.
  - JR: pc_src = PC_SRC_REG, reg_wen = 0.
  - SYSCALL: ra1 = $v0, ra2 = $a0, reg_wen = 0.
  - ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE: sign-extend the immediate.
  - ANDI, ORI, XORI: zero-extend the immediate.
  - LUI: alu_op = LUI code, ra1 = 0.
  - BEQ/BNE: reg_wen = 0, alu_op = F_SUB, pc_src = PC_SRC_BRCH.
  - SW: reg_wen = 0, mem_cmd = MEM_WRITE.
  - LW: reg_src = REG_SRC_MEM, mem_cmd = MEM_READ.
  - J: reg_wen = 0, pc_src = PC_SRC_JUMP.
  - JAL: wa = RA_REG, reg_wen = 1, reg_src = REG_SRC_PC8, pc_src = PC_SRC_JUMP.
  - Unknown opcode: decodes as a NOP (reg_wen = 0, MEM_NOP, PC_SRC_NEXT) and still passes through.
- Hazard (combinational on in_inst):
  - Asserted if any source register actually read by the instruction is pending, or if the destination is pending while reg_wen = 1.
  - Register 0 is never pending.
  - Hazard checks use the scoreboard with the same-cycle wb clear already applied (writeback bypass into the interlock).
  - With SERIALISE_SYSCALL = 1, SYSCALL also stalls while busy = 1.
- Scoreboard update:
  - On accept with reg_wen = 1 and wa != 0, set bit[wa].
  - On wb_valid, clear bit[wb_addr].
  - If set and clear hit the same register in the same cycle, set wins.
  - wb_valid for a register that is not pending is ignored.
  - busy = OR of all scoreboard bits.
- Flush:
  - out_valid goes to 0 on the next edge and no accept happens that cycle.
  - The scoreboard is not cleared, because already-issued writes still return. A squashed bundle's scoreboard bit is cleared by execute issuing a wb_valid for it.
  - Flush has priority over out_ready and over any accept.
- Reset mid-stall: everything returns to reset values immediately and the pending scoreboard is discarded.

Decomposition:
- Shared package (opcodes header) holds:
  - the OP_*/F_* codes, including new JAL, JR and LUI;
  - W_REG, W_IMM, W_JADDR;
  - PC_SRC_*, including new PC_SRC_REG;
  - REG_SRC_*, including new REG_SRC_PC8;
  - MEM_*, ALU_SRC_*, IMM_*_EXT;
  - REG_V0, REG_A0.
- One sub-module, decode_comb: pure combinational instruction-to-control-bundle mapping plus the read-use flags (uses_rs, uses_rt).
- decode_stage itself adds the output register, handshake, scoreboard and hazard logic.

Test Plan:
- Back-to-back independent ops: ADDI $t0,$0,5 then ORI $t1,$0,3, out_ready = 1. Expect one bundle per cycle; second bundle imm_ext = 0, out_wa = 9.
- RAW stall: ADDI $t0 then ADD $t2,$t0,$t1 with no wb. Expect in_ready = 0 until wb_valid with wb_addr = 8, then accept in that same cycle.
- Backpressure: out_ready = 0 for 3 cycles with LW in the output register. Expect fields stable, in_ready = 0, mem_cmd = MEM_READ held.
- Same-cycle set/clear: wb_valid with wb_addr = 8 while accepting ADDI $t0. Expect bit 8 still set afterwards and busy = 1.
- JAL and SYSCALL: JAL gives wa = 31 and reg_src = REG_SRC_PC8. SYSCALL with $v0 pending stalls until its wb, then ra1 = 2, ra2 = 4.
- Flush and reset: flush while out_valid = 1 gives out_valid = 0 next cycle with the scoreboard intact. rst_n low mid-stall gives busy = 0 and out_valid = 0 asynchronously.
